crossbar_shift_feeder: RTL

- Upstream stage of the crossbar shift unit in the convolution datapath.
- Collects a serial stream of input words into NUM_LANES-wide banks, using two ping-pong banks.
- Replays each full bank to the crossbar for NUM_SHIFTS consecutive enabled cycles, driving the crossbar's timestamp and clk_en inputs.
- Filling one bank overlaps with shifting the other, so the crossbar sees gap-free issue.

---
 rtl/crossbar_shift_feeder.sv | 115 +++++++++++
 1 files changed

// File: rtl/crossbar_shift_feeder.sv
// Gathers a serial word stream into two ping-pong banks and replays each full bank
// to the crossbar for NUM_SHIFTS enabled cycles. Issue starts one edge after the bank fills.
module crossbar_shift_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 8,
  parameter int NUM_SHIFTS = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clk_en,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [2:0]                      timestamp,
  output logic                            xbar_en,
  output logic                            bank_done,
  output logic                            idle
);

  localparam int             LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LW-1:0]  LAST_LANE = LW'(NUM_LANES - 1);
  localparam logic [2:0]     LAST_TS   = 3'(NUM_SHIFTS - 1);
  localparam logic           ONE_SHIFT = 1'(NUM_SHIFTS == 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                               state;
  logic [1:0]                           full;
  logic                                 wr_sel;
  logic                                 rd_sel;
  logic [LW-1:0]                        lane_cnt;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] bank [2];
  logic                                 accept;
  logic                                 last_word;
  logic                                 release_bank;

  assign in_ready     = clk_en & ~full[wr_sel];
  assign accept       = in_valid & in_ready;
  assign last_word    = accept & (lane_cnt == LAST_LANE);
  assign release_bank = clk_en & (state == SHIFT) & (timestamp == LAST_TS);
  assign idle         = (state == IDLE) & ~full[0] & ~full[1] & (lane_cnt == '0);

  // Bank storage is not reset; the full flags alone decide what is meaningful.
  always_ff @(posedge clk) begin
    if (accept) bank[wr_sel][lane_cnt] <= in_data;
  end

  // The writer only ever fills a non-full bank while release only clears a full one,
  // so a set and a clear on the same edge always hit different bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 2'b00;
      wr_sel   <= 1'b0;
      lane_cnt <= '0;
    end else begin
      if (accept) begin
        if (last_word) begin
          lane_cnt <= '0;
          wr_sel   <= ~wr_sel;
        end else begin
          lane_cnt <= lane_cnt + 1'b1;
        end
      end
      if (last_word)    full[wr_sel] <= 1'b1;
      if (release_bank) full[rd_sel] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_sel    <= 1'b0;
      timestamp <= 3'd0;
      xbar_en   <= 1'b0;
      bank_done <= 1'b0;
      out_data  <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (full[rd_sel]) begin
            state     <= SHIFT;
            out_data  <= bank[rd_sel];
            timestamp <= 3'd0;
            xbar_en   <= 1'b1;
            bank_done <= ONE_SHIFT;
          end else begin
            xbar_en   <= 1'b0;
            bank_done <= 1'b0;
          end
        end
        SHIFT: begin
          if (timestamp != LAST_TS) begin
            timestamp <= timestamp + 3'd1;
            bank_done <= ((timestamp + 3'd1) == LAST_TS);
          end else begin
            rd_sel <= ~rd_sel;
            // Back-to-back reload keeps the crossbar busy without a bubble.
            if (full[~rd_sel]) begin
              out_data  <= bank[~rd_sel];
              timestamp <= 3'd0;
              bank_done <= ONE_SHIFT;
            end else begin
              state     <= IDLE;
              xbar_en   <= 1'b0;
              bank_done <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
